mac_array_feeder: RTL and testbench

- Hardware sequencer that drives a MacArray's weight-prefetch and ifmap ports.
- It replaces stimulus sequencing that would otherwise live in a bench.
- Buffers one full weight tile from a valid/ready stream, replays it bottom-row-first under a prefetch pulse, then streams a programmable number of ifmap vectors with per-row diagonal skew.
- Upstream stalls travel through the skew as per-row enable bubbles.

---
 rtl/mac_array_feeder.sv | 172 +++++++++++++++++
 tb/tb_mac_array_feeder.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_feeder.sv
// Sequencer for a MacArray: buffers one weight tile, replays it bottom-row-first
// under a prefetch pulse, then streams ifmap vectors through a per-row diagonal skew.
module mac_array_feeder #(
    parameter int unsigned MAC_ROW        = 16,
    parameter int unsigned MAC_COL        = 16,
    parameter int unsigned IFMAP_BITWIDTH = 16,
    parameter int unsigned W_BITWIDTH     = 8,
    parameter int unsigned VEC_CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start_in,
    input  logic [VEC_CNT_W-1:0]              vec_num_in,
    input  logic                              w_valid_in,
    output logic                              w_ready_out,
    input  logic [MAC_COL*W_BITWIDTH-1:0]     w_row_in,
    input  logic                              if_valid_in,
    output logic                              if_ready_out,
    input  logic [MAC_ROW*IFMAP_BITWIDTH-1:0] if_vec_in,
    output logic                              w_prefetch_out,
    output logic                              w_enable_out,
    output logic [MAC_COL*W_BITWIDTH-1:0]     w_data_out,
    output logic                              ifmap_start_out,
    output logic [MAC_ROW-1:0]                ifmap_enable_out,
    output logic [MAC_ROW*IFMAP_BITWIDTH-1:0] ifmap_data_out,
    output logic                              busy_out,
    output logic                              done_out
);
    localparam int unsigned ROW_W  = (MAC_ROW > 1) ? $clog2(MAC_ROW) : 1;
    localparam int unsigned WROW_W = MAC_COL * W_BITWIDTH;
    localparam int unsigned IW     = IFMAP_BITWIDTH;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAC_ROW - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_W_COLLECT = 3'd1;
    localparam logic [2:0] S_W_PULSE   = 3'd2;
    localparam logic [2:0] S_W_LOAD    = 3'd3;
    localparam logic [2:0] S_IF_PULSE  = 3'd4;
    localparam logic [2:0] S_IF_STREAM = 3'd5;
    localparam logic [2:0] S_DRAIN     = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    logic [2:0]           state, state_d;
    logic [ROW_W-1:0]     row, row_d;
    logic [VEC_CNT_W-1:0] vec_num, vec_num_d;
    logic [VEC_CNT_W-1:0] vec_cnt, vec_cnt_d;
    logic [WROW_W-1:0]    wbuf [MAC_ROW];
    logic                 w_hs;
    logic                 if_hs;

    // Ready outputs mirror the current state, so a handshake implies the right state.
    assign w_hs  = w_valid_in & w_ready_out;
    assign if_hs = if_valid_in & if_ready_out;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            row     <= '0;
            vec_num <= '0;
            vec_cnt <= '0;
        end else begin
            state   <= state_d;
            row     <= row_d;
            vec_num <= vec_num_d;
            vec_cnt <= vec_cnt_d;
        end
    end

    // row counts up while collecting, down while replaying, and times the drain.
    always_comb begin
        state_d   = state;
        row_d     = row;
        vec_num_d = vec_num;
        vec_cnt_d = vec_cnt;
        case (state)
            S_IDLE: begin
                if (start_in) begin
                    state_d   = S_W_COLLECT;
                    row_d     = '0;
                    vec_num_d = vec_num_in;
                    vec_cnt_d = '0;
                end
            end
            S_W_COLLECT: begin
                if (w_hs) begin
                    if (row == ROW_LAST) state_d = S_W_PULSE;
                    else                 row_d   = row + ROW_W'(1);
                end
            end
            S_W_PULSE: state_d = S_W_LOAD;
            S_W_LOAD: begin
                if (row == '0) state_d = (vec_num == '0) ? S_DONE : S_IF_PULSE;
                else           row_d   = row - ROW_W'(1);
            end
            S_IF_PULSE: state_d = S_IF_STREAM;
            S_IF_STREAM: begin
                if (if_hs) begin
                    vec_cnt_d = vec_cnt + VEC_CNT_W'(1);
                    if (vec_cnt_d == vec_num) begin
                        if (MAC_ROW > 1) begin
                            state_d = S_DRAIN;
                            row_d   = ROW_W'(1);
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (row == ROW_LAST) state_d = S_DONE;
                else                 row_d   = row + ROW_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Weight tile storage; intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_hs) wbuf[row] <= w_row_in;
    end

    // Registered Moore outputs decoded from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            w_ready_out     <= 1'b0;
            if_ready_out    <= 1'b0;
            w_prefetch_out  <= 1'b0;
            w_enable_out    <= 1'b0;
            w_data_out      <= '0;
            ifmap_start_out <= 1'b0;
        end else begin
            busy_out        <= (state_d != S_IDLE);
            done_out        <= (state_d == S_DONE);
            w_ready_out     <= (state_d == S_W_COLLECT);
            if_ready_out    <= (state_d == S_IF_STREAM);
            w_prefetch_out  <= (state_d == S_W_PULSE);
            w_enable_out    <= (state_d == S_W_LOAD);
            w_data_out      <= (state_d == S_W_LOAD) ? wbuf[row_d] : '0;
            ifmap_start_out <= (state_d == S_IF_PULSE);
        end
    end

    // Lane r delays each accepted element by r+1 cycles; idle cycles inject zero bubbles.
    genvar r;
    generate
        for (r = 0; r < MAC_ROW; r++) begin : g_lane
            logic [r:0]    en_sr;
            logic [IW-1:0] d_sr [r+1];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    en_sr <= '0;
                    for (int i = 0; i <= r; i++) d_sr[i] <= '0;
                end else begin
                    en_sr[0] <= if_hs;
                    d_sr[0]  <= if_hs ? if_vec_in[r*IW +: IW] : '0;
                    for (int i = 1; i <= r; i++) begin
                        en_sr[i] <= en_sr[i-1];
                        d_sr[i]  <= d_sr[i-1];
                    end
                end
            end

            assign ifmap_enable_out[r]        = en_sr[r];
            assign ifmap_data_out[r*IW +: IW] = d_sr[r];
        end
    endgenerate

endmodule

// File: tb/tb_mac_array_feeder.sv
// Randomized bench for mac_array_feeder: per-cycle output traces compared against
// a timeline model built from handshake rules with plain arithmetic.
module tb_mac_array_feeder;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int IW   = 16;
    localparam int WW   = 8;
    localparam int VW   = 16;
    localparam int MAXC = 256;

    typedef struct packed {
        logic                 busy;
        logic                 done;
        logic                 w_ready;
        logic                 if_ready;
        logic                 prefetch;
        logic                 w_en;
        logic                 ifs;
        logic [ROWS-1:0]      if_en;
        logic [COLS*WW-1:0]   w_data;
        logic [ROWS*IW-1:0]   if_data;
    } obs_t;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 start_in;
    logic [VW-1:0]        vec_num_in;
    logic                 w_valid_in;
    logic                 w_ready_out;
    logic [COLS*WW-1:0]   w_row_in;
    logic                 if_valid_in;
    logic                 if_ready_out;
    logic [ROWS*IW-1:0]   if_vec_in;
    logic                 w_prefetch_out;
    logic                 w_enable_out;
    logic [COLS*WW-1:0]   w_data_out;
    logic                 ifmap_start_out;
    logic [ROWS-1:0]      ifmap_enable_out;
    logic [ROWS*IW-1:0]   ifmap_data_out;
    logic                 busy_out;
    logic                 done_out;

    int checks = 0;
    int errors = 0;

    logic [COLS*WW-1:0] rows [ROWS];
    logic [ROWS*IW-1:0] vecs [64];
    bit                 wpat [MAXC];
    bit                 ipat [MAXC];
    obs_t               exp_tr [MAXC];
    obs_t               tr [MAXC];
    int                 exp_len;
    int                 exp_d;
    int                 exp_cw;

    mac_array_feeder #(
        .MAC_ROW(ROWS), .MAC_COL(COLS), .IFMAP_BITWIDTH(IW), .W_BITWIDTH(WW), .VEC_CNT_W(VW)
    ) dut (
        .clk(clk), .rstn(rstn), .start_in(start_in), .vec_num_in(vec_num_in),
        .w_valid_in(w_valid_in), .w_ready_out(w_ready_out), .w_row_in(w_row_in),
        .if_valid_in(if_valid_in), .if_ready_out(if_ready_out), .if_vec_in(if_vec_in),
        .w_prefetch_out(w_prefetch_out), .w_enable_out(w_enable_out), .w_data_out(w_data_out),
        .ifmap_start_out(ifmap_start_out), .ifmap_enable_out(ifmap_enable_out),
        .ifmap_data_out(ifmap_data_out), .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic obs_t sample();
        obs_t o;
        o.busy     = busy_out;
        o.done     = done_out;
        o.w_ready  = w_ready_out;
        o.if_ready = if_ready_out;
        o.prefetch = w_prefetch_out;
        o.w_en     = w_enable_out;
        o.ifs      = ifmap_start_out;
        o.if_en    = ifmap_enable_out;
        o.w_data   = w_data_out;
        o.if_data  = ifmap_data_out;
        return o;
    endfunction

    task automatic gen_stim(input int wdens, input int idens);
        for (int i = 0; i < ROWS; i++) rows[i] = {$urandom};
        for (int i = 0; i < 64; i++) vecs[i] = {$urandom, $urandom};
        for (int c = 0; c < MAXC; c++) begin
            wpat[c] = (c >= 40)  ? 1'b1 : ($urandom_range(99) < wdens);
            ipat[c] = (c >= 150) ? 1'b1 : ($urandom_range(99) < idens);
        end
    endtask

    // Expected timeline: collect from cycle 1, pulse, reversed replay, ifmap pulse,
    // stream, lane r of a vector accepted at cycle a appears at a+1+r, done at last+ROWS.
    task automatic build_model(input int vn, input bit chain);
        int c, nw, cw, nacc, last;
        for (int i = 0; i < MAXC; i++) exp_tr[i] = '0;
        c = 1; nw = 0; cw = 0;
        while (nw < ROWS) begin
            exp_tr[c].w_ready = 1'b1;
            if (wpat[c]) begin nw++; cw = c; end
            c++;
        end
        exp_tr[cw+1].prefetch = 1'b1;
        for (int j = 0; j < ROWS; j++) begin
            exp_tr[cw+2+j].w_en   = 1'b1;
            exp_tr[cw+2+j].w_data = rows[ROWS-1-j];
        end
        if (vn == 0) begin
            exp_d = cw + 2 + ROWS;
        end else begin
            exp_tr[cw+2+ROWS].ifs = 1'b1;
            c = cw + 3 + ROWS; nacc = 0; last = c;
            while (nacc < vn) begin
                exp_tr[c].if_ready = 1'b1;
                if (ipat[c]) begin
                    for (int r = 0; r < ROWS; r++) begin
                        exp_tr[c+1+r].if_en[r]            = 1'b1;
                        exp_tr[c+1+r].if_data[r*IW +: IW] = vecs[nacc][r*IW +: IW];
                    end
                    nacc++; last = c;
                end
                c++;
            end
            exp_d = last + ROWS;
        end
        exp_tr[exp_d].done = 1'b1;
        for (int i = 1; i <= exp_d; i++) exp_tr[i].busy = 1'b1;
        exp_cw  = cw;
        exp_len = chain ? exp_d + 1 : exp_d + 2;
    endtask

    // Drives one job cycle by cycle and records outputs; cycle 0 carries start_in.
    task automatic run_job(input int vn, input bit hold, input int max_len);
        int nw, ni, len;
        len = (max_len > 0 && max_len < exp_len) ? max_len : exp_len;
        nw = 0; ni = 0;
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            tr[c]       = sample();
            start_in    = (c == 0) || (hold && c <= exp_d);
            vec_num_in  = (c == 0) ? VW'(vn) : VW'($urandom);
            w_valid_in  = (c >= 1) && wpat[c];
            w_row_in    = (nw < ROWS) ? rows[nw] : {$urandom};
            if_valid_in = ipat[c];
            if_vec_in   = (ni < 64) ? vecs[ni] : '0;
            if (w_valid_in && w_ready_out)  nw++;
            if (if_valid_in && if_ready_out) ni++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start_in = 1'b0; vec_num_in = '0; w_valid_in = 1'b0;
        w_row_in = '0; if_valid_in = 1'b0; if_vec_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sample() !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0", sample());
        end
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sample() !== obs_t'(0)) begin
            errors++;
            $display("FAIL idle_after_reset got %h expected 0", sample());
        end
    endtask

    task automatic test_weight_replay();
        gen_stim(100, 100);
        build_model(3, 1'b0);
        run_job(3, 1'b0, 0);
        for (int i = 0; i < exp_len; i++) begin
            checks++;
            if (tr[i] !== exp_tr[i]) begin
                errors++;
                $display("FAIL replay cycle %0d got %h expected %h", i, tr[i], exp_tr[i]);
            end
        end
        checks++;
        if (tr[5].prefetch !== 1'b1 || tr[6].w_data !== rows[3] || tr[9].w_data !== rows[0]) begin
            errors++;
            $display("FAIL replay_order got pf=%b d6=%h d9=%h expected pf=1 d6=%h d9=%h",
                     tr[5].prefetch, tr[6].w_data, tr[9].w_data, rows[3], rows[0]);
        end
        checks++;
        if (tr[16].done !== 1'b0 || tr[17].done !== 1'b1 || tr[18].busy !== 1'b0) begin
            errors++;
            $display("FAIL continuous_done got d16=%b d17=%b b18=%b expected 0 1 0",
                     tr[16].done, tr[17].done, tr[18].busy);
        end
    endtask

    task automatic test_if_gap();
        gen_stim(100, 100);
        ipat[12] = 1'b0;
        build_model(3, 1'b0);
        run_job(3, 1'b0, 0);
        for (int i = 0; i < exp_len; i++) begin
            checks++;
            if (tr[i] !== exp_tr[i]) begin
                errors++;
                $display("FAIL if_gap cycle %0d got %h expected %h", i, tr[i], exp_tr[i]);
            end
        end
        checks++;
        if (tr[13].if_en !== 4'b0010 || tr[17].done !== 1'b0 || tr[18].done !== 1'b1) begin
            errors++;
            $display("FAIL if_gap_timing got en13=%b d17=%b d18=%b expected 0010 0 1",
                     tr[13].if_en, tr[17].done, tr[18].done);
        end
    endtask

    task automatic test_zero_vectors();
        int n_ifs;
        gen_stim(100, 100);
        build_model(0, 1'b0);
        run_job(0, 1'b0, 0);
        n_ifs = 0;
        for (int i = 0; i < exp_len; i++) begin
            if (tr[i].ifs) n_ifs++;
            checks++;
            if (tr[i] !== exp_tr[i]) begin
                errors++;
                $display("FAIL zero_vec cycle %0d got %h expected %h", i, tr[i], exp_tr[i]);
            end
        end
        checks++;
        if (n_ifs !== 0 || tr[10].done !== 1'b1) begin
            errors++;
            $display("FAIL zero_vec_summary got ifs=%0d done10=%b expected 0 1", n_ifs, tr[10].done);
        end
    endtask

    task automatic test_start_held();
        gen_stim(70, 70);
        build_model(5, 1'b0);
        run_job(5, 1'b1, 0);
        for (int i = 0; i < exp_len; i++) begin
            checks++;
            if (tr[i] !== exp_tr[i]) begin
                errors++;
                $display("FAIL start_held cycle %0d got %h expected %h", i, tr[i], exp_tr[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 2; j++) begin
            int vn;
            vn = $urandom_range(1, 8);
            gen_stim(60, 60);
            build_model(vn, (j == 0));
            run_job(vn, 1'b0, 0);
            for (int i = 0; i < exp_len; i++) begin
                checks++;
                if (tr[i] !== exp_tr[i]) begin
                    errors++;
                    $display("FAIL back_to_back job %0d cycle %0d got %h expected %h",
                             j, i, tr[i], exp_tr[i]);
                end
            end
        end
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 6; j++) begin
            int vn;
            vn = (j == 0) ? 1 : $urandom_range(1, 20);
            gen_stim(50, 60);
            build_model(vn, 1'b0);
            run_job(vn, 1'b0, 0);
            for (int i = 0; i < exp_len; i++) begin
                checks++;
                if (tr[i] !== exp_tr[i]) begin
                    errors++;
                    $display("FAIL random job %0d vn %0d cycle %0d got %h expected %h",
                             j, vn, i, tr[i], exp_tr[i]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int abort_c;
        gen_stim(50, 100);
        build_model(10, 1'b0);
        abort_c = exp_cw + 3 + ROWS + 2;
        run_job(10, 1'b0, abort_c + 1);
        for (int i = 0; i <= abort_c; i++) begin
            checks++;
            if (tr[i] !== exp_tr[i]) begin
                errors++;
                $display("FAIL mid_reset_pre cycle %0d got %h expected %h", i, tr[i], exp_tr[i]);
            end
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (sample() !== obs_t'(0)) begin
            errors++;
            $display("FAIL mid_reset_async got %h expected 0", sample());
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done_out !== 1'b0 || busy_out !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_hold got done=%b busy=%b expected 0 0", done_out, busy_out);
            end
        end
        @(negedge clk) rstn = 1'b1;
        gen_stim(60, 60);
        build_model(6, 1'b0);
        run_job(6, 1'b0, 0);
        for (int i = 0; i < exp_len; i++) begin
            checks++;
            if (tr[i] !== exp_tr[i]) begin
                errors++;
                $display("FAIL after_reset cycle %0d got %h expected %h", i, tr[i], exp_tr[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_weight_replay();
        test_if_gap();
        test_zero_vectors();
        test_start_held();
        test_back_to_back();
        test_random_jobs();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
